lif_neuron: RTL and testbench

Leaky integrate-and-fire neuron that consumes the rate-coded spike trains produced by the encoder neuron stage. Each cycle it:
- sums programmable signed weights for the asserted spike inputs,
- applies a shift-based leak to a saturating signed membrane potential,
- fires a one-cycle output spike on threshold crossing, followed by a fixed refractory period.

Weights and threshold are runtime-writable through a simple register-write interface.

---
 rtl/lif_neuron.sv | 149 ++++++++++++++
 tb/tb_lif_neuron.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/lif_neuron.sv
// lif_neuron: leaky integrate-and-fire neuron.
//
// Each enabled cycle the neuron does three things. It adds up the weights of
// the asserted spike inputs. It subtracts a shift-based leak from the membrane
// potential. It fires a one-cycle output spike when the saturated result
// reaches the threshold. After firing, the neuron sits in a refractory period
// of REFRAC_CYCLES cycles. During that period the inputs are ignored.
//
// Ports:
//   clk        system clock
//   reset      synchronous active-high reset, highest priority
//   enable     1 = neuron advances, 0 = membrane/state/counter freeze
//   spike_in   one bit per encoder spike output
//   w_we       weight write strobe
//   w_addr     weight index; indices >= NUM_IN are dropped
//   w_data     signed weight value
//   thr_we     threshold write strobe
//   thr_data   unsigned threshold
//   spike_out  registered output spike, one cycle wide
//   membrane   current signed membrane potential
//   refractory high while the neuron is refractory
module lif_neuron #(
    parameter int NUM_IN         = 4,
    parameter int W_WIDTH        = 4,
    parameter int V_WIDTH        = 8,
    parameter int LEAK_SHIFT     = 3,
    parameter int REFRAC_CYCLES  = 3,
    parameter int THRESH_DEFAULT = 32,
    parameter int W_DEFAULT      = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [NUM_IN-1:0]         spike_in,
    input  logic                      w_we,
    // One bit wider than a bare index so out-of-range addresses can be
    // expressed and then ignored.
    input  logic [$clog2(NUM_IN):0]   w_addr,
    input  logic [W_WIDTH-1:0]        w_data,
    input  logic                      thr_we,
    input  logic [V_WIDTH-2:0]        thr_data,
    output logic                      spike_out,
    output logic [V_WIDTH-1:0]        membrane,
    output logic                      refractory
);

    localparam int S_W   = W_WIDTH + $clog2(NUM_IN) + 1;
    localparam int F_W   = ((V_WIDTH > S_W) ? V_WIDTH : S_W) + 2;
    localparam int CNT_W = (REFRAC_CYCLES > 0) ? $clog2(REFRAC_CYCLES + 1) : 1;

    localparam logic signed [F_W-1:0] VMAX_F = F_W'(2 ** (V_WIDTH - 1) - 1);
    localparam logic signed [F_W-1:0] VMIN_F = -VMAX_F - F_W'(1);

    typedef enum logic {INTEGRATE, REFRACTORY} state_t;

    state_t                     state_q;
    logic [CNT_W-1:0]           cnt_q;
    logic signed [V_WIDTH-1:0]  v_q;
    logic                       spike_q;
    logic [V_WIDTH-2:0]         thr_q;
    logic signed [W_WIDTH-1:0]  weight_q [NUM_IN];

    logic signed [S_W-1:0]      sum;
    logic signed [V_WIDTH-1:0]  leak;
    logic signed [F_W-1:0]      vFull;
    logic signed [V_WIDTH-1:0]  vNext_d;
    logic                       fire;
    logic                       addrValid;

    // Weighted input sum plus leak, formed wide enough that neither step can
    // overflow. The result is then clamped into the membrane range. The clamp
    // keeps a strongly inhibited neuron pinned at the minimum instead of
    // letting it wrap around to a large positive value.
    always_comb begin
        sum = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (spike_in[i]) begin
                sum = sum + {{(S_W - W_WIDTH){weight_q[i][W_WIDTH-1]}}, weight_q[i]};
            end
        end
        leak  = v_q >>> LEAK_SHIFT;
        vFull = {{(F_W - V_WIDTH){v_q[V_WIDTH-1]}}, v_q}
              - {{(F_W - V_WIDTH){leak[V_WIDTH-1]}}, leak}
              + {{(F_W - S_W){sum[S_W-1]}}, sum};
        if (vFull > VMAX_F) begin
            vNext_d = VMAX_F[V_WIDTH-1:0];
        end else if (vFull < VMIN_F) begin
            vNext_d = VMIN_F[V_WIDTH-1:0];
        end else begin
            vNext_d = vFull[V_WIDTH-1:0];
        end
        // Threshold is unsigned, so zero-extend it before the signed compare.
        fire      = vNext_d >= $signed({1'b0, thr_q});
        addrValid = int'(w_addr) < NUM_IN;
    end

    // Main state machine and register file. Weight and threshold writes land
    // at the edge regardless of enable. Integration on the same edge still
    // sees the old values because it reads the registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= INTEGRATE;
            cnt_q   <= '0;
            v_q     <= '0;
            spike_q <= 1'b0;
            thr_q   <= (V_WIDTH - 1)'(THRESH_DEFAULT);
            for (int i = 0; i < NUM_IN; i++) begin
                weight_q[i] <= W_WIDTH'(W_DEFAULT);
            end
        end else begin
            if (w_we && addrValid) begin
                weight_q[w_addr[$clog2(NUM_IN)-1:0]] <= w_data;
            end
            if (thr_we) begin
                thr_q <= thr_data;
            end
            spike_q <= 1'b0;
            if (enable) begin
                case (state_q)
                    INTEGRATE: begin
                        if (fire) begin
                            spike_q <= 1'b1;
                            v_q     <= '0;
                            if (REFRAC_CYCLES > 0) begin
                                state_q <= REFRACTORY;
                                cnt_q   <= CNT_W'(REFRAC_CYCLES);
                            end
                        end else begin
                            v_q <= vNext_d;
                        end
                    end
                    REFRACTORY: begin
                        v_q   <= '0;
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state_q <= INTEGRATE;
                        end
                    end
                    default: state_q <= INTEGRATE;
                endcase
            end
        end
    end

    assign spike_out  = spike_q;
    assign membrane   = v_q;
    assign refractory = (state_q == REFRACTORY);

endmodule

// File: tb/tb_lif_neuron.sv
// tb_lif_neuron: self-checking bench for lif_neuron.
// A behavioural model computes the expected outputs for every cycle of
// stimulus. The results are queued and then compared after the clock edge
// that produces them.
module tb_lif_neuron;

    localparam int NUM_IN = 4;
    localparam int REFRAC = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] spike_in;
    logic       w_we;
    logic [2:0] w_addr;
    logic [3:0] w_data;
    logic       thr_we;
    logic [6:0] thr_data;
    logic       spike_out;
    logic [7:0] membrane;
    logic       refractory;

    int checkCount = 0;
    int failCount  = 0;

    // Model state
    int mV, mState, mCnt, mThr, mSpike;
    int mW [NUM_IN];

    typedef struct {
        string tag;
        int    spk;
        int    mem;
        int    refr;
    } expect_t;

    expect_t scoreQ [$];

    lif_neuron dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .spike_in   (spike_in),
        .w_we       (w_we),
        .w_addr     (w_addr),
        .w_data     (w_data),
        .thr_we     (thr_we),
        .thr_data   (thr_data),
        .spike_out  (spike_out),
        .membrane   (membrane),
        .refractory (refractory)
    );

    always #5 clk = ~clk;

    // Watchdog so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic int floorDiv(input int v, input int d);
        if (v >= 0) return v / d;
        return -((-v + d - 1) / d);
    endfunction

    // Advance the model one edge using the given inputs.
    task automatic modelStep(input logic rst, input logic en, input logic [3:0] spk,
                             input logic wwe, input logic [2:0] waddr,
                             input logic signed [3:0] wdata,
                             input logic twe, input logic [6:0] tdata);
        int sum, vn;
        if (rst) begin
            mV = 0; mState = 0; mCnt = 0; mThr = 32; mSpike = 0;
            for (int i = 0; i < NUM_IN; i++) mW[i] = 4;
            return;
        end
        mSpike = 0;
        if (en) begin
            if (mState == 0) begin
                sum = 0;
                for (int i = 0; i < NUM_IN; i++) if (spk[i]) sum += mW[i];
                vn = mV - floorDiv(mV, 8) + sum;
                if (vn > 127) vn = 127;
                if (vn < -128) vn = -128;
                if (vn >= mThr) begin
                    mSpike = 1; mV = 0;
                    if (REFRAC > 0) begin mState = 1; mCnt = REFRAC; end
                end else begin
                    mV = vn;
                end
            end else begin
                mV = 0;
                if (mCnt == 1) mState = 0;
                mCnt--;
            end
        end
        if (wwe && int'(waddr) < NUM_IN) mW[waddr] = int'(wdata);
        if (twe) mThr = int'(tdata);
    endtask

    // Drive one cycle of stimulus, queue the expected result, then compare
    // once the DUT has clocked it in.
    task automatic applyStimulus(input string tag, input logic rst, input logic en,
                                 input logic [3:0] spk, input logic wwe,
                                 input logic [2:0] waddr, input logic [3:0] wdata,
                                 input logic twe, input logic [6:0] tdata);
        expect_t e, got;
        reset = rst; enable = en; spike_in = spk;
        w_we = wwe; w_addr = waddr; w_data = wdata;
        thr_we = twe; thr_data = tdata;
        modelStep(rst, en, spk, wwe, waddr, $signed(wdata), twe, tdata);
        e.tag = tag; e.spk = mSpike; e.mem = mV; e.refr = mState;
        scoreQ.push_back(e);
        @(posedge clk);
        #1;
        if (scoreQ.size() == 0) begin
            checkOutput({tag, "_queue"}, 0, 1);
        end else begin
            got = scoreQ.pop_front();
            checkOutput({got.tag, "_spike"}, int'(spike_out), got.spk);
            checkOutput({got.tag, "_mem"}, int'($signed(membrane)), got.mem);
            checkOutput({got.tag, "_refr"}, int'(refractory), got.refr);
        end
    endtask

    task automatic run(input string tag, input logic en, input logic [3:0] spk, input int n);
        for (int i = 0; i < n; i++) applyStimulus(tag, 1'b0, en, spk, 1'b0, 3'd0, 4'd0, 1'b0, 7'd0);
    endtask

    task automatic doReset();
        applyStimulus("reset", 1'b1, 1'b1, 4'b0000, 1'b0, 3'd0, 4'd0, 1'b0, 7'd0);
    endtask

    task automatic writeW(input string tag, input logic [2:0] a, input logic [3:0] d, input logic [3:0] spk);
        applyStimulus(tag, 1'b0, 1'b1, spk, 1'b1, a, d, 1'b0, 7'd0);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; spike_in = '0;
        w_we = 1'b0; w_addr = '0; w_data = '0; thr_we = 1'b0; thr_data = '0;

        // 1: defaults, all inputs high: 16, 30, fire, three refractory cycles, 16
        doReset();
        checkOutput("t1_reset_mem", int'($signed(membrane)), 0);
        checkOutput("t1_reset_refr", int'(refractory), 0);
        run("t1_int", 1'b1, 4'b1111, 2);
        checkOutput("t1_v30", int'($signed(membrane)), 30);
        run("t1_fire", 1'b1, 4'b1111, 1);
        checkOutput("t1_fire_spike", int'(spike_out), 1);
        run("t1_refr", 1'b1, 4'b1111, 3);
        run("t1_resume", 1'b1, 4'b1111, 1);
        checkOutput("t1_resume16", int'($signed(membrane)), 16);

        // 2: weight0 = 7, three pulses then leak down to a held 7
        doReset();
        writeW("t2_wr", 3'd0, 4'd7, 4'b0000);
        run("t2_pulse", 1'b1, 4'b0001, 3);
        checkOutput("t2_v20", int'($signed(membrane)), 20);
        run("t2_leak", 1'b1, 4'b0000, 12);
        checkOutput("t2_hold7", int'($signed(membrane)), 7);

        // 3: all weights -8, saturate at -128
        doReset();
        for (int i = 0; i < NUM_IN; i++) writeW("t3_wr", 3'(i), 4'b1000, 4'b0000);
        run("t3_neg", 1'b1, 4'b1111, 8);
        checkOutput("t3_sat", int'($signed(membrane)), -128);

        // 4: threshold 127, weights 7: positive saturation then fire
        doReset();
        applyStimulus("t4_thr", 1'b0, 1'b1, 4'b0000, 1'b0, 3'd0, 4'd0, 1'b1, 7'd127);
        for (int i = 0; i < NUM_IN; i++) writeW("t4_wr", 3'(i), 4'd7, 4'b0000);
        run("t4_int", 1'b1, 4'b1111, 6);
        checkOutput("t4_v126", int'($signed(membrane)), 126);
        run("t4_fire", 1'b1, 4'b1111, 1);
        checkOutput("t4_fire_spike", int'(spike_out), 1);

        // 5: enable freeze during integration and during refractory
        doReset();
        run("t5_int", 1'b1, 4'b1111, 2);
        run("t5_freeze", 1'b0, 4'b1111, 3);
        checkOutput("t5_hold30", int'($signed(membrane)), 30);
        run("t5_fire", 1'b1, 4'b1111, 1);
        run("t5_refr1", 1'b1, 4'b1111, 1);
        run("t5_rfreeze", 1'b0, 4'b1111, 3);
        run("t5_refr_rest", 1'b1, 4'b1111, 3);

        // 6: same-edge weight write, out-of-range write, threshold 0, reset in refractory
        doReset();
        writeW("t6_same", 3'd0, 4'b1101, 4'b0001);
        checkOutput("t6_oldw", int'($signed(membrane)), 4);
        run("t6_neww", 1'b1, 4'b0001, 1);
        writeW("t6_oob", 3'd4, 4'd7, 4'b0000);
        run("t6_oobchk", 1'b1, 4'b0001, 1);
        applyStimulus("t6_thr0", 1'b0, 1'b1, 4'b0000, 1'b0, 3'd0, 4'd0, 1'b1, 7'd0);
        run("t6_fire0", 1'b1, 4'b0000, 2);
        doReset();
        run("t6_toref", 1'b1, 4'b1111, 4);
        doReset();
        checkOutput("t6_rst_refr", int'(refractory), 0);
        checkOutput("t6_rst_mem", int'($signed(membrane)), 0);
        run("t6_thr32", 1'b1, 4'b1111, 3);

        // Random mix of inputs and writes against the model
        doReset();
        for (int i = 0; i < 60; i++) begin
            applyStimulus("rand", 1'b0, ($urandom_range(0, 7) != 0), 4'($urandom),
                          ($urandom_range(0, 5) == 0), 3'($urandom_range(0, 4)), 4'($urandom),
                          ($urandom_range(0, 15) == 0), 7'($urandom_range(10, 60)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
